// File: rtl/spi_req_arbiter_pkg.sv
// Shared types and constants for the SPI request arbiter.
package spi_req_arbiter_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ARB, ST_START, ST_WAIT, ST_RESP, ST_GAP
  } arb_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/spi_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);
  logic [IW-1:0] w_j;

  // Scan from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end
endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin sharing of one spi_master: grant, start, wait (with watchdog),
// return the rx word to the owner, then hold CS idle for GAP_CYC cycles.
module spi_req_arbiter
  import spi_req_arbiter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int N_REQ   = 4,
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_vld,
  input  logic [N_REQ*WIDTH-1:0]   i_req_data,
  input  logic [N_REQ*2-1:0]       i_req_mode,
  output logic [N_REQ-1:0]         o_req_rdy,
  output logic [N_REQ-1:0]         o_rsp_vld,
  output logic [WIDTH-1:0]         o_rsp_data,
  output logic                     o_rsp_err,
  output logic                     o_busy,
  output logic                     o_spi_start,
  output logic [WIDTH-1:0]         o_spi_din,
  output logic [1:0]               o_spi_mode,
  input  logic                     i_spi_rdy,
  input  logic [WIDTH-1:0]         i_spi_dout
);
  localparam int IW       = $clog2(N_REQ);
  localparam int CW       = $clog2(max2(TIMEOUT, GAP_CYC) + 1);
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  arb_state_e       r_state;
  logic [IW-1:0]    r_ptr;
  logic [N_REQ-1:0] r_gnt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_din;
  logic [1:0]       r_mode;
  logic             r_spi_start;
  logic [N_REQ-1:0] r_rsp_vld;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;
  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_gidx;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .i_req (i_req_vld),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx)
  );

  // Accept is shown in the ARB cycle itself; the handshake completes on its closing edge.
  assign o_req_rdy   = (r_state == ST_ARB) ? w_gnt : '0;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_spi_start = r_spi_start;
  assign o_spi_din   = r_din;
  assign o_spi_mode  = r_mode;
  assign o_rsp_vld   = r_rsp_vld;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_din       <= '0;
      r_mode      <= '0;
      r_spi_start <= 1'b0;
      r_rsp_vld   <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_spi_start <= 1'b0;
      r_rsp_vld   <= '0;
      case (r_state)
        ST_IDLE: if (|i_req_vld) r_state <= ST_ARB;
        ST_ARB: begin
          if (|i_req_vld) begin
            r_gnt       <= w_gnt;
            r_din       <= i_req_data[w_gidx*WIDTH +: WIDTH];
            r_mode      <= i_req_mode[w_gidx*2 +: 2];
            r_ptr       <= (w_gidx == IW'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
            r_spi_start <= 1'b1;
            r_state     <= ST_START;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_START: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion landing on the expiry cycle still counts as success.
          if (i_spi_rdy) begin
            r_rsp_data <= i_spi_dout;
            r_rsp_err  <= 1'b0;
            r_rsp_vld  <= r_gnt;
            r_state    <= ST_RESP;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_rsp_vld  <= r_gnt;
            r_state    <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_cnt   <= '0;
          r_state <= (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          if (r_cnt == CW'(GAP_LAST)) r_state <= ST_IDLE;
          else                        r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
